// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode hex 7-segment display.
// A shadow copy of the value and decimal points is loaded on 'upd'. The
// display is scanned one digit per slot of REFRESH_DIV clocks, and each nibble
// is decoded to a segment pattern.
//
// At the start of every slot, all digit selects are held off for GUARD cycles
// so that the previous digit's pattern cannot ghost onto the new digit.
//
// When leading-zero blanking is enabled, zero digits above the most
// significant non-zero digit are blanked. Digit 0 is never blanked.
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   upd        in   1           load strobe: value/dp_in -> shadow registers
//   value      in   4*N_DIGITS  hex digits, digit i = value[4i+3:4i], 0 = LSD
//   dp_in      in   N_DIGITS    decimal point per digit, 1 = lit
//   lz_en      in   1           1 = blank leading zeros (sampled at slot start)
//   seg        out  8           {dp, a..g}, active-high, registered
//   dig_n      out  N_DIGITS    active-low digit select, registered
//   frame_done out  1           one-cycle pulse when the scan enters digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_en,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     dig_n,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    // Set on the first tick after reset; keeps all digits dark until then.
    logic                    active_reg, active_next;
    logic [4*N_DIGITS-1:0]   shadow_val_reg;
    logic [N_DIGITS-1:0]     shadow_dp_reg;
    logic [7:0]              seg_reg, seg_next;
    logic [N_DIGITS-1:0]     dig_n_reg, dig_n_next;
    logic                    frame_done_reg, frame_done_next;

    logic                    tick;
    logic                    guard_over;

    logic [N_DIGITS-1:0]     nib_zero;
    logic [N_DIGITS-1:0]     zero_from;
    logic [7:0]              digit_pat [N_DIGITS];

    // Hex nibble to {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h72;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h73;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    // Per-digit segment pattern from the shadow registers. zero_from[k] is set
    // when digits k..N_DIGITS-1 are all zero, which is the blanking condition.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib_zero[gi]  = (shadow_val_reg[4*gi +: 4] == 4'h0);
            assign zero_from[gi] = &nib_zero[N_DIGITS-1:gi];
            if (gi == 0) begin : g_lsd
                assign digit_pat[gi] = {shadow_dp_reg[gi],
                                        hex_to_seg(shadow_val_reg[4*gi +: 4])};
            end else begin : g_upper
                assign digit_pat[gi] = {shadow_dp_reg[gi],
                                        (lz_en && zero_from[gi]) ? 7'h00
                                        : hex_to_seg(shadow_val_reg[4*gi +: 4])};
            end
        end
    endgenerate

    // Digit select is enabled once the slot counter has passed the guard window.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_over = 1'b1;
        end else begin : g_guard
            assign guard_over = (cnt_next >= CNT_W'(GUARD));
        end
    endgenerate

    assign tick = (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next        = tick ? '0 : cnt_reg + 1'b1;
        idx_next        = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        active_next     = active_reg | tick;
        // seg only changes at a slot boundary, from the shadow as it was before
        // this edge; an upd on the same edge is seen one slot later.
        seg_next        = tick ? digit_pat[idx_next] : seg_reg;
        frame_done_next = tick && (idx_next == '0);
        // Computed from next-state values so the registered select lines up
        // with the slot counter; one-hot-low or all ones, never two digits.
        dig_n_next      = '1;
        if (active_next && guard_over) begin
            dig_n_next[idx_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            active_reg     <= 1'b0;
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            seg_reg        <= 8'h00;
            dig_n_reg      <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            active_reg     <= active_next;
            seg_reg        <= seg_next;
            dig_n_reg      <= dig_n_next;
            frame_done_reg <= frame_done_next;
            if (upd) begin
                shadow_val_reg <= value;
                shadow_dp_reg  <= dp_in;
            end
        end
    end

    assign seg        = seg_reg;
    assign dig_n      = dig_n_reg;
    assign frame_done = frame_done_reg;

endmodule
